// File: rtl/dbus_pkg.sv
// Shared definitions for the data bus and its two-master arbiter.
package dbus_pkg;

  localparam int AW_DEF = 16;
  localparam int DW_DEF = 16;

  localparam int M0 = 0;
  localparam int M1 = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } own_t;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way winner select with lock/hold and round-robin fallback.
module rr_pick2
  import dbus_pkg::*;
#(
  parameter int PRIO_M0 = 1
) (
  input  logic [1:0] req,
  input  logic [1:0] last,
  input  logic       lock,
  input  logic       hold_ok,
  output logic [1:0] win
);

  always_comb begin
    win = 2'b00;
    if (req[M0] ^ req[M1]) begin
      win = req;
    end else if (req[M0] && req[M1]) begin
      if (last == 2'b00)
        win = (PRIO_M0 != 0) ? 2'b01 : 2'b10;
      else if (lock && hold_ok)
        win = last;
      else
        win = ~last;
    end
  end

endmodule

// File: rtl/dbus_arbiter.sv
// Two-master arbiter for the shared data bus: grant, bus mux and read-return routing.
module dbus_arbiter
  import dbus_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int HOLD_MAX = 8,
  parameter int PRIO_M0  = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic          m0_lock,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_din,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic          m1_lock,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_din,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_din,
  output logic          bus_we,
  input  logic [DW-1:0] bus_dout
);

  localparam int HW = $clog2(HOLD_MAX + 1);
  localparam logic [HW-1:0] HOLD_LIM = HW'(HOLD_MAX);

  own_t          state, state_nxt;
  logic [HW-1:0] hold_cnt, hold_nxt;
  logic [1:0]    req, last, win_raw, win;
  logic          own_lock, hold_ok, other_req, rd_acc;
  logic          rd_pend_p1, rd_own_p1;
  logic [DW-1:0] m0_rdata_q, m1_rdata_q;

  assign req      = {m1_req, m0_req};
  assign last     = (state == OWN0) ? 2'b01 : (state == OWN1) ? 2'b10 : 2'b00;
  assign own_lock = (state == OWN0) ? m0_lock : (state == OWN1) ? m1_lock : 1'b0;
  assign hold_ok  = (hold_cnt < HOLD_LIM);

  rr_pick2 #(.PRIO_M0(PRIO_M0)) u_pick (
    .req     (req),
    .last    (last),
    .lock    (own_lock),
    .hold_ok (hold_ok),
    .win     (win_raw)
  );

  // Grants are suppressed while reset is held so the bus is quiet immediately.
  assign win    = rst_n ? win_raw : 2'b00;
  assign m0_gnt = win[M0];
  assign m1_gnt = win[M1];

  always_comb begin
    bus_we   = 1'b0;
    bus_addr = '0;
    bus_din  = '0;
    if (win[M0]) begin
      bus_we   = m0_we;
      bus_addr = m0_addr;
      bus_din  = m0_din;
    end else if (win[M1]) begin
      bus_we   = m1_we;
      bus_addr = m1_addr;
      bus_din  = m1_din;
    end
  end

  assign rd_acc    = (|win) & ~bus_we;
  assign other_req = (win[M0] & m1_req) | (win[M1] & m0_req);

  always_comb begin
    state_nxt = IDLE;
    hold_nxt  = '0;
    if (win[M0])
      state_nxt = OWN0;
    else if (win[M1])
      state_nxt = OWN1;
    if ((|win) && (win == last) && other_req)
      hold_nxt = (hold_cnt == HOLD_LIM) ? hold_cnt : hold_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  // Stage 1: read issued last cycle, bus_dout now carries its data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend_p1 <= 1'b0;
      rd_own_p1  <= 1'b0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      rd_pend_p1 <= rd_acc;
      rd_own_p1  <= win[M1];
      if (m0_rvalid)
        m0_rdata_q <= bus_dout;
      if (m1_rvalid)
        m1_rdata_q <= bus_dout;
    end
  end

  assign m0_rvalid = rd_pend_p1 & ~rd_own_p1;
  assign m1_rvalid = rd_pend_p1 & rd_own_p1;
  assign m0_rdata  = m0_rvalid ? bus_dout : m0_rdata_q;
  assign m1_rdata  = m1_rvalid ? bus_dout : m1_rdata_q;

endmodule

// File: tb/tb_dbus_arbiter.sv
// Bench for dbus_arbiter with a one-cycle-latency memory standing in for dbus.
module tb_dbus_arbiter;

  typedef struct packed {
    logic        own;
    logic [15:0] data;
  } rd_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_req = 1'b0, m0_we = 1'b0, m0_lock = 1'b0;
  logic [15:0] m0_addr = '0, m0_din = '0;
  logic        m1_req = 1'b0, m1_we = 1'b0, m1_lock = 1'b0;
  logic [15:0] m1_addr = '0, m1_din = '0;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, bus_we;
  logic [15:0] m0_rdata, m1_rdata, bus_addr, bus_din;
  logic [15:0] bus_dout = '0;

  logic [15:0] bmem    [0:65535];
  logic [15:0] exp_mem [0:65535];
  rd_t         sb[$];
  rd_t         e;
  int          n_cmp = 0;
  int          n_bad = 0;

  dbus_arbiter #(.AW(16), .DW(16), .HOLD_MAX(8), .PRIO_M0(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_din(m0_din),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_din(m1_din),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .bus_addr(bus_addr), .bus_din(bus_din), .bus_we(bus_we), .bus_dout(bus_dout)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] init_val(input logic [15:0] a);
    return a ^ 16'h5A5A;
  endfunction

  initial begin
    for (int i = 0; i < 65536; i++) begin
      bmem[i]    = init_val(16'(i));
      exp_mem[i] = init_val(16'(i));
    end
  end

  // dbus stand-in: synchronous write, read data one cycle after the address.
  always @(posedge clk) begin
    if (bus_we)
      bmem[bus_addr] <= bus_din;
    bus_dout <= bmem[bus_addr];
  end

  // c = {req, we, lock}; inputs change just after the rising edge, checks happen at the falling edge.
  task automatic drv(input logic [2:0] c0, input logic [15:0] a0, input logic [15:0] d0,
                     input logic [2:0] c1, input logic [15:0] a1, input logic [15:0] d1);
    @(posedge clk);
    #1;
    {m0_req, m0_we, m0_lock} = c0;
    m0_addr = a0;
    m0_din  = d0;
    {m1_req, m1_we, m1_lock} = c1;
    m1_addr = a1;
    m1_din  = d1;
    @(negedge clk);
  endtask

  task automatic test_reset;
    m0_req = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({m0_gnt, m1_gnt, bus_we, m0_rvalid, m1_rvalid} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_gnt: got %b expected 00000", {m0_gnt, m1_gnt, bus_we, m0_rvalid, m1_rvalid});
    end
    @(posedge clk);
    #1;
    m0_req = 1'b0;
    rst_n  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drv(3'b000, 16'h1234, 16'h5678, 3'b000, 16'h4321, 16'h8765);
      n_cmp++;
      if ({m0_gnt, m1_gnt, bus_we, m0_rvalid, m1_rvalid, bus_addr, bus_din, m0_rdata, m1_rdata} !== '0) begin
        n_bad++;
        $display("FAIL idle_outputs: cycle %0d gnt=%b%b we=%b rv=%b%b addr=%h din=%h rd0=%h rd1=%h expected all zero",
                 i, m0_gnt, m1_gnt, bus_we, m0_rvalid, m1_rvalid, bus_addr, bus_din, m0_rdata, m1_rdata);
      end
    end
  endtask

  task automatic test_write_read;
    drv(3'b110, 16'h0010, 16'hBEEF, 3'b000, 16'h0000, 16'h0000);
    n_cmp++;
    if ({m0_gnt, m1_gnt, bus_we, bus_addr, bus_din} !== {3'b101, 16'h0010, 16'hBEEF}) begin
      n_bad++;
      $display("FAIL wr_issue: got gnt=%b%b we=%b addr=%h din=%h expected 1 0 1 0010 beef",
               m0_gnt, m1_gnt, bus_we, bus_addr, bus_din);
    end
    exp_mem[16'h0010] = 16'hBEEF;
    drv(3'b000, 16'h0000, 16'h0000, 3'b100, 16'h0010, 16'h0000);
    n_cmp++;
    if ({m0_gnt, m1_gnt, bus_we, bus_addr} !== {3'b010, 16'h0010}) begin
      n_bad++;
      $display("FAIL rd_issue: got gnt=%b%b we=%b addr=%h expected 0 1 0 0010", m0_gnt, m1_gnt, bus_we, bus_addr);
    end
    if (m1_gnt) sb.push_back('{1'b1, exp_mem[16'h0010]});
    for (int i = 0; i < 2; i++) begin
      drv(3'b000, 16'h0000, 16'h0000, 3'b000, 16'h0000, 16'h0000);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        n_cmp++;
        if ({m1_rvalid, m0_rvalid, (e.own ? m1_rdata : m0_rdata)} !== {e.own, ~e.own, e.data}) begin
          n_bad++;
          $display("FAIL wr_rd_return: got rv1=%b rv0=%b data=%h expected owner m%0d data=%h",
                   m1_rvalid, m0_rvalid, e.own ? m1_rdata : m0_rdata, e.own, e.data);
        end
      end else begin
        n_cmp++;
        if ({m1_rvalid, m0_rvalid, m1_rdata, m0_rdata} !== {2'b00, 16'hBEEF, 16'h0000}) begin
          n_bad++;
          $display("FAIL rdata_hold: got rv=%b%b rd1=%h rd0=%h expected 00 beef 0000",
                   m1_rvalid, m0_rvalid, m1_rdata, m0_rdata);
        end
      end
    end
  endtask

  task automatic test_round_robin;
    logic [1:0] exp_g;
    drv(3'b000, 16'h0000, 16'h0000, 3'b000, 16'h0000, 16'h0000);
    for (int i = 0; i < 7; i++) begin
      if (i < 6) drv(3'b100, 16'h0100 + 16'(i), 16'h0, 3'b100, 16'h0200 + 16'(i), 16'h0);
      else       drv(3'b000, 16'h0000, 16'h0, 3'b000, 16'h0000, 16'h0);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        n_cmp++;
        if ({m1_rvalid, m0_rvalid, (e.own ? m1_rdata : m0_rdata)} !== {e.own, ~e.own, e.data}) begin
          n_bad++;
          $display("FAIL rr_return: cycle %0d got rv1=%b rv0=%b data=%h expected owner m%0d data=%h",
                   i, m1_rvalid, m0_rvalid, e.own ? m1_rdata : m0_rdata, e.own, e.data);
        end
      end
      if (i < 6) begin
        exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
        n_cmp++;
        if ({m1_gnt, m0_gnt} !== exp_g) begin
          n_bad++;
          $display("FAIL rr_grant: cycle %0d got m1,m0=%b expected %b", i, {m1_gnt, m0_gnt}, exp_g);
        end
        if (m0_gnt) sb.push_back('{1'b0, exp_mem[m0_addr]});
        if (m1_gnt) sb.push_back('{1'b1, exp_mem[m1_addr]});
      end
    end
  endtask

  task automatic test_lock_hold;
    logic [1:0]  exp_g;
    logic [15:0] exp_a;
    drv(3'b000, 16'h0000, 16'h0000, 3'b000, 16'h0000, 16'h0000);
    for (int k = 0; k < 11; k++) begin
      if (k == 0)      drv(3'b000, 16'h0300, 16'h0, 3'b101, 16'h0040, 16'h0);
      else if (k < 10) drv(3'b110, 16'h0300, 16'hA000 + 16'(k), 3'b101, 16'h0040 + 16'(k), 16'h0);
      else             drv(3'b000, 16'h0000, 16'h0, 3'b000, 16'h0000, 16'h0);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        n_cmp++;
        if ({m1_rvalid, m0_rvalid, (e.own ? m1_rdata : m0_rdata)} !== {e.own, ~e.own, e.data}) begin
          n_bad++;
          $display("FAIL lock_return: cycle %0d got rv1=%b rv0=%b data=%h expected owner m%0d data=%h",
                   k, m1_rvalid, m0_rvalid, e.own ? m1_rdata : m0_rdata, e.own, e.data);
        end
      end
      if (k < 10) begin
        exp_g = (k <= 8) ? 2'b10 : 2'b01;
        exp_a = (k <= 8) ? 16'h0040 + 16'(k) : 16'h0300;
        n_cmp++;
        if ({m1_gnt, m0_gnt, bus_addr} !== {exp_g, exp_a}) begin
          n_bad++;
          $display("FAIL lock_grant: cycle %0d got m1,m0=%b addr=%h expected %b addr=%h",
                   k, {m1_gnt, m0_gnt}, bus_addr, exp_g, exp_a);
        end
        if (m0_gnt) exp_mem[m0_addr] = m0_din;
        if (m1_gnt) sb.push_back('{1'b1, exp_mem[m1_addr]});
      end
    end
  endtask

  task automatic test_lock_alone;
    logic [1:0] exp_g;
    drv(3'b000, 16'h0000, 16'h0000, 3'b000, 16'h0000, 16'h0000);
    for (int k = 0; k < 13; k++) begin
      if (k < 4) drv(3'b111, 16'h0400, 16'h1100 + 16'(k), 3'b000, 16'h0500, 16'h0);
      else       drv(3'b111, 16'h0400, 16'h1100 + 16'(k), 3'b110, 16'h0500, 16'h2200 + 16'(k));
      exp_g = (k < 12) ? 2'b01 : 2'b10;
      n_cmp++;
      if ({m1_gnt, m0_gnt} !== exp_g) begin
        n_bad++;
        $display("FAIL lock_alone: cycle %0d got m1,m0=%b expected %b", k, {m1_gnt, m0_gnt}, exp_g);
      end
      if (m0_gnt) exp_mem[m0_addr] = m0_din;
      if (m1_gnt) exp_mem[m1_addr] = m1_din;
    end
    drv(3'b000, 16'h0000, 16'h0000, 3'b000, 16'h0000, 16'h0000);
  endtask

  task automatic test_back_to_back;
    drv(3'b000, 16'h0000, 16'h0000, 3'b000, 16'h0000, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      if (i == 0)      drv(3'b100, 16'h2000, 16'h0, 3'b000, 16'h0000, 16'h0);
      else if (i == 1) drv(3'b000, 16'h0000, 16'h0, 3'b100, 16'h0004, 16'h0);
      else             drv(3'b000, 16'h0000, 16'h0, 3'b000, 16'h0000, 16'h0);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        n_cmp++;
        if ({m1_rvalid, m0_rvalid, (e.own ? m1_rdata : m0_rdata)} !== {e.own, ~e.own, e.data}) begin
          n_bad++;
          $display("FAIL b2b_return: cycle %0d got rv1=%b rv0=%b data=%h expected owner m%0d data=%h",
                   i, m1_rvalid, m0_rvalid, e.own ? m1_rdata : m0_rdata, e.own, e.data);
        end
      end else begin
        n_cmp++;
        if ({m1_rvalid, m0_rvalid} !== 2'b00) begin
          n_bad++;
          $display("FAIL b2b_spurious: cycle %0d got rv1,rv0=%b expected 00", i, {m1_rvalid, m0_rvalid});
        end
      end
      if (m0_gnt && !bus_we) sb.push_back('{1'b0, exp_mem[16'h2000]});
      if (m1_gnt && !bus_we) sb.push_back('{1'b1, exp_mem[16'h0004]});
    end
    n_cmp++;
    if (m0_rdata !== init_val(16'h2000)) begin
      n_bad++;
      $display("FAIL b2b_m0_hold: got %h expected %h", m0_rdata, init_val(16'h2000));
    end
  endtask

  task automatic test_reset_mid_read;
    drv(3'b000, 16'h0000, 16'h0000, 3'b000, 16'h0000, 16'h0000);
    drv(3'b100, 16'h0008, 16'h0000, 3'b000, 16'h0000, 16'h0000);
    n_cmp++;
    if ({m0_gnt, m1_gnt, bus_we} !== 3'b100) begin
      n_bad++;
      $display("FAIL rst_rd_issue: got gnt=%b%b we=%b expected 1 0 0", m0_gnt, m1_gnt, bus_we);
    end
    @(posedge clk);
    #1;
    rst_n  = 1'b0;
    m0_req = 1'b0;
    sb.delete();
    @(negedge clk);
    n_cmp++;
    if ({m0_rvalid, m1_rvalid, m0_rdata, m1_rdata, m0_gnt, m1_gnt} !== '0) begin
      n_bad++;
      $display("FAIL rst_mid_read: got rv=%b%b rd0=%h rd1=%h gnt=%b%b expected all zero",
               m0_rvalid, m1_rvalid, m0_rdata, m1_rdata, m0_gnt, m1_gnt);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drv(3'b110, 16'h0600, 16'h00AA, 3'b110, 16'h0700, 16'h00BB);
    n_cmp++;
    if ({m0_gnt, m1_gnt, bus_addr, m0_rvalid, m1_rvalid} !== {2'b10, 16'h0600, 2'b00}) begin
      n_bad++;
      $display("FAIL rst_first_grant: got gnt=%b%b addr=%h rv=%b%b expected 10 0600 00",
               m0_gnt, m1_gnt, bus_addr, m0_rvalid, m1_rvalid);
    end
    drv(3'b000, 16'h0000, 16'h0000, 3'b000, 16'h0000, 16'h0000);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_round_robin();
    test_lock_hold();
    test_lock_alone();
    test_back_to_back();
    test_reset_mid_read();
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL sb_drain: got %0d reads outstanding expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
